// File: rtl/ball_collision_resolver_if.sv
// Request/response bundle for the ball-pair collision resolver.
// Positions are unsigned pixels; velocities are two's-complement pixels/frame.
interface ball_collision_resolver_if #(
   parameter int P_W = 10,
   parameter int V_W = 10
);
   // Both channels use valid/ready: a beat transfers on a rising clk edge where
   // valid && ready. The payload must be stable while valid is high and not yet
   // accepted, and valid must not be withdrawn before the transfer.
   logic                  in_valid;
   logic                  in_ready;
   logic [P_W-1:0]        xa, ya, xb, yb;
   logic signed [V_W-1:0] vax, vay, vbx, vby;

   logic                  out_valid;
   logic                  out_ready;
   logic signed [V_W-1:0] vax_o, vay_o, vbx_o, vby_o;
   logic                  hit;

   modport master (
      output in_valid, xa, ya, xb, yb, vax, vay, vbx, vby, out_ready,
      input  in_ready, out_valid, vax_o, vay_o, vbx_o, vby_o, hit
   );

   modport slave (
      input  in_valid, xa, ya, xb, yb, vax, vay, vbx, vby, out_ready,
      output in_ready, out_valid, vax_o, vay_o, vbx_o, vby_o, hit
   );
endinterface

// File: rtl/ball_collision_resolver.sv
// Sequential equal-mass elastic collision resolver for one ball pair per request.
// The impulse along the centre line is computed with one shared restoring divider.
module ball_collision_resolver #(
   parameter int P_W       = 10,
   parameter int V_W       = 10,
   parameter int BALL_DIAM = 30
) (
   input  logic                     clk,
   input  logic                     rst,
   ball_collision_resolver_if.slave bus,
   output logic [2:0]               dbg_state
);
   localparam int DIV_BITS = 2*P_W + V_W + 4;
   localparam int D_W      = P_W + 1;
   localparam int R_W      = V_W + 1;
   localparam int D2_W     = 2*P_W + 1;
   localparam int DOT_W    = P_W + V_W + 3;
   localparam int Q_W      = V_W + 1;
   localparam int I_W      = V_W + 2;
   localparam int S_W      = V_W + 3;
   localparam int CNT_W    = $clog2(DIV_BITS + 1);

   localparam logic [D2_W-1:0]       THRESH = D2_W'(BALL_DIAM * BALL_DIAM);
   localparam logic signed [S_W-1:0] V_MAX  = S_W'((1 <<< (V_W-1)) - 1);
   localparam logic signed [S_W-1:0] V_MIN  = S_W'(-(1 <<< (V_W-1)));

   typedef enum logic [2:0] {
      S_IDLE, S_DELTA, S_PROD, S_CHECK, S_DIVX, S_DIVY, S_APPLY, S_DONE
   } state_t;

   state_t state, state_nx;

   logic                     rdy_q;
   logic [P_W-1:0]           s_xa, s_ya, s_xb, s_yb;
   logic signed [V_W-1:0]    s_vax, s_vay, s_vbx, s_vby;
   logic signed [D_W-1:0]    dx, dy;
   logic signed [R_W-1:0]    rvx, rvy;
   logic [D2_W-1:0]          d2;
   logic signed [DOT_W-1:0]  dot;
   logic [DIV_BITS-1:0]      div_num;
   logic [D2_W-1:0]          div_rem;
   logic [Q_W-1:0]           div_quo;
   logic [CNT_W-1:0]         div_cnt;
   logic signed [I_W-1:0]    ix, iy;
   logic signed [V_W-1:0]    o_vax, o_vay, o_vbx, o_vby;
   logic                     hit_q;

   logic                     accept;
   logic                     collide;
   logic                     div_last;
   logic [P_W-1:0]           mag_dx, mag_dy;
   logic [DOT_W-1:0]         mag_dot;
   logic [DIV_BITS-1:0]      num_x, num_y;
   logic [D2_W:0]            rem_shift;
   logic                     rem_ge;
   logic [D2_W-1:0]          rem_next;
   logic [Q_W-1:0]           quo_next;
   logic                     imp_neg;
   logic signed [I_W-1:0]    imp_next;

   function automatic logic signed [V_W-1:0] sat(input logic signed [S_W-1:0] v);
      if (v > V_MAX)      return V_W'(V_MAX);
      else if (v < V_MIN) return V_W'(V_MIN);
      else                return V_W'(v);
   endfunction

   function automatic logic signed [I_W-1:0] apply_sign(input logic [Q_W-1:0] m,
                                                        input logic neg);
      logic signed [I_W-1:0] t;
      t = $signed({1'b0, m});
      return neg ? -t : t;
   endfunction

   assign bus.in_ready  = (state == S_IDLE) && rdy_q;
   assign bus.out_valid = (state == S_DONE);
   assign bus.vax_o     = o_vax;
   assign bus.vay_o     = o_vay;
   assign bus.vbx_o     = o_vbx;
   assign bus.vby_o     = o_vby;
   assign bus.hit       = hit_q;
   assign dbg_state     = state;

   assign accept  = bus.in_valid && bus.in_ready;
   assign mag_dx  = P_W'(dx[D_W-1] ? -dx : dx);
   assign mag_dy  = P_W'(dy[D_W-1] ? -dy : dy);
   assign mag_dot = DOT_W'(dot[DOT_W-1] ? -dot : dot);
   assign num_x   = DIV_BITS'(mag_dot) * DIV_BITS'(mag_dx);
   assign num_y   = DIV_BITS'(mag_dot) * DIV_BITS'(mag_dy);
   assign collide = (d2 != '0) && (d2 <= THRESH) && dot[DOT_W-1];

   // One restoring step: bring down the next numerator bit, subtract d2 if it fits.
   // The true quotient never exceeds |rv|, so only the low Q_W bits are kept.
   assign rem_shift = {div_rem, div_num[DIV_BITS-1]};
   assign rem_ge    = rem_shift >= {1'b0, d2};
   assign rem_next  = D2_W'(rem_ge ? (rem_shift - {1'b0, d2}) : rem_shift);
   assign quo_next  = Q_W'({div_quo, rem_ge});
   assign div_last  = (div_cnt == CNT_W'(DIV_BITS - 1));
   assign imp_neg   = (state == S_DIVX) ? dx[D_W-1] : dy[D_W-1];
   assign imp_next  = apply_sign(quo_next, imp_neg);

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_DELTA;
         S_DELTA: state_nx = S_PROD;
         S_PROD:  state_nx = S_CHECK;
         S_CHECK: state_nx = collide ? S_DIVX : S_DONE;
         S_DIVX:  if (div_last) state_nx = S_DIVY;
         S_DIVY:  if (div_last) state_nx = S_APPLY;
         S_APPLY: state_nx = S_DONE;
         S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdy_q   <= 1'b0;
         s_xa    <= '0;
         s_ya    <= '0;
         s_xb    <= '0;
         s_yb    <= '0;
         s_vax   <= '0;
         s_vay   <= '0;
         s_vbx   <= '0;
         s_vby   <= '0;
         dx      <= '0;
         dy      <= '0;
         rvx     <= '0;
         rvy     <= '0;
         d2      <= '0;
         dot     <= '0;
         div_num <= '0;
         div_rem <= '0;
         div_quo <= '0;
         div_cnt <= '0;
         ix      <= '0;
         iy      <= '0;
         o_vax   <= '0;
         o_vay   <= '0;
         o_vbx   <= '0;
         o_vby   <= '0;
         hit_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  s_xa  <= bus.xa;
                  s_ya  <= bus.ya;
                  s_xb  <= bus.xb;
                  s_yb  <= bus.yb;
                  s_vax <= bus.vax;
                  s_vay <= bus.vay;
                  s_vbx <= bus.vbx;
                  s_vby <= bus.vby;
               end
            end
            S_DELTA: begin
               dx  <= $signed({1'b0, s_xb}) - $signed({1'b0, s_xa});
               dy  <= $signed({1'b0, s_yb}) - $signed({1'b0, s_ya});
               rvx <= $signed({s_vbx[V_W-1], s_vbx}) - $signed({s_vax[V_W-1], s_vax});
               rvy <= $signed({s_vby[V_W-1], s_vby}) - $signed({s_vay[V_W-1], s_vay});
            end
            S_PROD: begin
               d2  <= D2_W'(mag_dx) * D2_W'(mag_dx) + D2_W'(mag_dy) * D2_W'(mag_dy);
               dot <= DOT_W'(rvx) * DOT_W'(dx) + DOT_W'(rvy) * DOT_W'(dy);
            end
            S_CHECK: begin
               if (collide) begin
                  div_num <= num_x;
                  div_rem <= '0;
                  div_quo <= '0;
                  div_cnt <= '0;
               end else begin
                  o_vax <= s_vax;
                  o_vay <= s_vay;
                  o_vbx <= s_vbx;
                  o_vby <= s_vby;
                  hit_q <= 1'b0;
               end
            end
            S_DIVX, S_DIVY: begin
               div_num <= div_num << 1;
               div_rem <= rem_next;
               div_quo <= quo_next;
               div_cnt <= div_cnt + 1'b1;
               if (div_last) begin
                  // The x pass hands over to the y pass with a fresh divider load.
                  if (state == S_DIVX) begin
                     ix      <= imp_next;
                     div_num <= num_y;
                  end else begin
                     iy <= imp_next;
                  end
                  div_rem <= '0;
                  div_quo <= '0;
                  div_cnt <= '0;
               end
            end
            S_APPLY: begin
               o_vax <= sat(S_W'(s_vax) - S_W'(ix));
               o_vbx <= sat(S_W'(s_vbx) + S_W'(ix));
               o_vay <= sat(S_W'(s_vay) - S_W'(iy));
               o_vby <= sat(S_W'(s_vby) + S_W'(iy));
               hit_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/ball_collision_resolver.md
Name: ball_collision_resolver

Overview:
- Sequential, parametrised successor to the combinational ball-pair collision velocity update.
- Takes one pair of ball centres and signed two's-complement velocities per transaction.
- Detects overlap and approach, then applies an exact equal-mass elastic impulse along the centre line using a shared iterative divider.
- Sits between the per-frame ball position/velocity registers and the physics update stage, one pair per request.

Parameters:
- P_W, 10, unsigned position width (pixels).
- V_W, 10, signed velocity width (two's complement, pixels/frame).
- BALL_DIAM, 30, ball diameter in pixels; the collision threshold is centre distance <= BALL_DIAM.
- DIV_BITS (localparam), 2*P_W+V_W+4, numerator width and restoring-divider iteration count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block idle, can accept
- xa, ya, xb, yb  in  P_W each  ball a / ball b centres, unsigned
- vax, vay, vbx, vby  in  V_W each  current velocities, signed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- vax_o, vay_o, vbx_o, vby_o  out  V_W each  updated velocities, signed
- hit  out  1  impulse applied for this result

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst.
  - While rst=0 at a clk edge: state=IDLE, in_ready=0, out_valid=0, hit=0, all velocity outputs=0, divider cleared.
  - in_ready rises the cycle after rst returns high.
  - Reset mid-operation abandons the transaction; no result is emitted.
- Input handshake: accept when in_valid&&in_ready at an edge; all inputs are registered.
  - in_ready=1 only in IDLE.
  - Input changes while busy are ignored.
- FSM states: IDLE -> DELTA -> PROD -> CHECK -> {DONE | DIVX -> DIVY -> APPLY -> DONE} -> IDLE.
- DELTA:
  - dx=xb-xa, dy=yb-ya (signed P_W+1).
  - rvx=vbx-vax, rvy=vby-vay (signed V_W+1).
- PROD:
  - d2=dx*dx+dy*dy, unsigned, full width, no truncation.
  - dot=rvx*dx+rvy*dy, signed, full width.
- CHECK: collision iff d2!=0 AND d2<=BALL_DIAM^2 AND dot<0.
  - Otherwise go to DONE with hit=0 and outputs equal to the registered input velocities.
- DIVX: ix = trunc-toward-zero(|dot|*|dx| / d2), sign of dx applied.
  - Restoring divide, one quotient bit per cycle, exactly DIV_BITS cycles.
- DIVY: iy computed the same way from dy, reusing the same divider, DIV_BITS cycles.
- APPLY:
  - vax_o=sat(vax-ix), vbx_o=sat(vbx+ix), vay_o=sat(vay-iy), vby_o=sat(vby+iy).
  - sat clamps to [-2^(V_W-1), 2^(V_W-1)-1].
  - Momentum is exact unless saturation occurs.
- Latency, from the acceptance edge to out_valid high:
  - 3 cycles when no hit.
  - 4+2*DIV_BITS cycles when hit (72 with defaults).
- Output handshake: DONE holds out_valid=1 and stable outputs/hit until out_valid&&out_ready at an edge, then returns to IDLE.
  - in_ready is asserted the following cycle, so there is no overlap between transactions.
  - Outputs keep their last values after the handshake; only out_valid drops.
- Boundaries:
  - Coincident centres (d2=0): hit=0, pass-through.
  - Exactly touching (d2=BALL_DIAM^2) counts as a collision.
  - dot=0 (tangential motion): hit=0.
  - Quotient magnitude is at most |rv| <= 2^V_W, so it always fits V_W+1 bits before saturation.

Test Plan:
- Head-on: a(100,100) v(5,0), b(130,100) v(-3,0) -> d2=900, dot=-240, ix=8, iy=0. Expect out (-3,0),(5,0), hit=1, out_valid exactly 72 cycles after accept.
- Separating: same positions, va=(-5,0), vb=(3,0) -> dot=+240. Expect hit=0, outputs equal inputs, latency 3.
- Diagonal, truncation: a(100,100) v(4,0), b(118,124) v(0,0) -> d2=900, dot=-72, ix=1 (1296/900), iy=1 (1728/900). Expect va'=(3,-1), vb'=(1,1), momentum sums (4,0) preserved.
- No overlap or coincident:
  - b at (200,100) -> d2=10000>900, hit=0, pass-through.
  - b=a -> d2=0, hit=0, pass-through, no divider activity.
- Extremes, negative dx: a(130,100) v(-512,0), b(100,100) v(511,0) -> dx=-30, ix=-1023. Expect va'=511, vb'=-512, no saturation fault.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0.
  - Then start a new transaction and drive rst=0 during DIVX: next cycle out_valid=0 and outputs 0; in_ready=1 one cycle after rst=1; the abandoned result is never emitted.
